audio_pwm_ctrl: RTL and testbench

AUDIO_PWM_CTRL -- requirements
Module: audio_pwm_ctrl

---
 rtl/audio_pkg.sv | 18 +
 rtl/sample_fifo.sv | 47 ++++
 rtl/audio_pwm_ctrl.sv | 138 +++++++++++++
 tb/tb_audio_pwm_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio PWM playback path.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2
    } state_t;

    localparam logic [7:0] MIDSCALE = 8'h80;
    localparam logic [7:0] SILENCE  = 8'h00;

    // Signed two's complement to offset binary: adding 0x80 mod 256 flips the MSB.
    function automatic logic [7:0] to_offset(input logic [7:0] s);
        return s ^ 8'h80;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Sample FIFO with first-word fall-through read data and a synchronous flush.
module sample_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int          AW  = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW + 1)'(1);
    localparam logic [AW:0] CAP = (AW + 1)'(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + ONE;
            if (pop && !empty)
                rd_ptr <= rd_ptr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == CAP);
    assign empty = (level == '0);
    assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/audio_pwm_ctrl.sv
// Audio playback controller: sample-rate divider, prime/play FSM and 8-bit PWM.
module audio_pwm_ctrl
    import audio_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int PRIME_LVL = 4
) (
    input  logic                     CLK12,
    input  logic                     RST,
    input  logic                     CFG_EN,
    input  logic [11:0]              CFG_DIV,
    input  logic [7:0]               SAMPLE,
    input  logic                     SAMPLE_VALID,
    output logic                     SAMPLE_READY,
    input  logic                     UNDERRUN_CLR,
    output logic                     AUDIO_PWM,
    output logic                     UNDERRUN,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     PLAYING,
    output state_t                   fsm_state
);
    logic [11:0] div_cnt;
    logic        tick;
    logic        en_q;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        underrun_set;
    logic [7:0]  fifo_dout;
    logic [7:0]  pend;
    logic [7:0]  duty;
    logic [7:0]  cnt;
    state_t      state;

    // tick is registered, so the pop it triggers lands one clock after the count hits 0.
    always_ff @(posedge CLK12) begin
        if (RST || !CFG_EN) begin
            div_cnt <= CFG_DIV;
            tick    <= 1'b0;
        end else begin
            tick <= (div_cnt == 12'd0);
            if (div_cnt == 12'd0)
                div_cnt <= CFG_DIV;
            else
                div_cnt <= div_cnt - 12'd1;
        end
    end

    always_ff @(posedge CLK12) begin
        if (RST)
            en_q <= 1'b0;
        else
            en_q <= CFG_EN;
    end

    // Producer handshake: a sample transfers on any cycle with SAMPLE_VALID && SAMPLE_READY.
    assign SAMPLE_READY = en_q && !full;
    assign push         = SAMPLE_VALID && SAMPLE_READY;
    assign pop          = tick && (state == PLAY) && !empty;
    assign underrun_set = CFG_EN && tick && (state == PLAY) && empty;

    sample_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (CLK12),
        .rst   (RST),
        .flush (!CFG_EN),
        .push  (push),
        .pop   (pop),
        .din   (SAMPLE),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (LEVEL)
    );

    always_ff @(posedge CLK12) begin
        if (RST || !CFG_EN) begin
            state   <= IDLE;
            pend    <= SILENCE;
            PLAYING <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= PRIME;
                    PLAYING <= 1'b0;
                end
                PRIME: begin
                    if (int'(LEVEL) >= PRIME_LVL) begin
                        state   <= PLAY;
                        PLAYING <= 1'b1;
                    end
                end
                PLAY: begin
                    // A push arriving on an empty tick is not bypassed; it only refills for re-priming.
                    if (tick) begin
                        if (empty) begin
                            pend    <= SILENCE;
                            state   <= PRIME;
                            PLAYING <= 1'b0;
                        end else begin
                            pend <= fifo_dout;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    PLAYING <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK12) begin
        if (RST)
            UNDERRUN <= 1'b0;
        else if (underrun_set)
            UNDERRUN <= 1'b1;
        else if (UNDERRUN_CLR)
            UNDERRUN <= 1'b0;
    end

    // Duty only reloads at the end of a frame so each PWM period is glitch-free.
    always_ff @(posedge CLK12) begin
        if (RST) begin
            cnt       <= 8'd0;
            duty      <= MIDSCALE;
            AUDIO_PWM <= 1'b0;
        end else begin
            cnt       <= cnt + 8'd1;
            AUDIO_PWM <= (cnt < duty);
            if (cnt == 8'hFF)
                duty <= to_offset(pend);
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_audio_pwm_ctrl.sv
// Self-checking bench for audio_pwm_ctrl against a queue/arithmetic reference model.
`timescale 1ns/1ps
module tb_audio_pwm_ctrl;
    import audio_pkg::*;

    localparam int DEPTH     = 8;
    localparam int PRIME_LVL = 4;

    logic        CLK12 = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_en = 1'b0;
    logic [11:0] cfg_div = 12'd255;
    logic [7:0]  sample = 8'h00;
    logic        sample_valid = 1'b0;
    logic        underrun_clr = 1'b0;
    logic        SAMPLE_READY;
    logic        AUDIO_PWM;
    logic        UNDERRUN;
    logic [3:0]  LEVEL;
    logic        PLAYING;
    state_t      fsm_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    state_t     m_state;
    int         m_pend, m_duty, m_clk, m_phase;
    bit         m_tick, m_under, m_pwm, m_en_q;

    audio_pwm_ctrl #(.DEPTH(DEPTH), .PRIME_LVL(PRIME_LVL)) dut (
        .CLK12(CLK12), .RST(rst), .CFG_EN(cfg_en), .CFG_DIV(cfg_div),
        .SAMPLE(sample), .SAMPLE_VALID(sample_valid), .SAMPLE_READY(SAMPLE_READY),
        .UNDERRUN_CLR(underrun_clr), .AUDIO_PWM(AUDIO_PWM), .UNDERRUN(UNDERRUN),
        .LEVEL(LEVEL), .PLAYING(PLAYING), .fsm_state(fsm_state)
    );

    always #42 CLK12 = ~CLK12;

    // Behavioural model: FIFO as a queue, divider and PWM counter as elapsed-clock arithmetic.
    task automatic model_update();
        int  cnt_old, old_size;
        bit  pushed, set_ur, old_tick;
        if (rst) begin
            exp_q.delete();
            m_state = IDLE; m_pend = 0; m_duty = 128; m_clk = 0; m_phase = 0;
            m_tick = 0; m_under = 0; m_pwm = 0; m_en_q = 0;
            return;
        end
        cnt_old = m_clk % 256;
        pushed  = sample_valid && m_en_q && (exp_q.size() < DEPTH);
        m_pwm   = (cnt_old < m_duty);
        if (cnt_old == 255) m_duty = (m_pend + 128) % 256;
        m_clk++;
        set_ur = 0;
        if (!cfg_en) begin
            exp_q.delete(); m_state = IDLE; m_pend = 0; m_phase = 0; m_tick = 0;
        end else begin
            old_tick = m_tick;
            old_size = exp_q.size();
            if (m_state == IDLE) m_state = PRIME;
            else if (m_state == PRIME) begin
                if (old_size >= PRIME_LVL) m_state = PLAY;
            end else if (old_tick) begin
                if (old_size == 0) begin set_ur = 1; m_pend = 0; m_state = PRIME; end
                else m_pend = int'(exp_q.pop_front());
            end
            if (pushed) exp_q.push_back(sample);
            m_tick = ((m_phase % (int'(cfg_div) + 1)) == int'(cfg_div));
            m_phase++;
        end
        if (set_ur) m_under = 1;
        else if (underrun_clr) m_under = 0;
        m_en_q = cfg_en;
    endtask

    task automatic step();
        @(posedge CLK12);
        model_update();
        @(negedge CLK12);
    endtask

    task automatic restart(input int div);
        cfg_en = 0; sample_valid = 0; underrun_clr = 0;
        step(); step();
        cfg_div = 12'(div);
        step();
        cfg_en = 1;
    endtask

    task automatic fill_to(input int n, input logic [7:0] v, output bit ok);
        ok = 0;
        sample_valid = 1; sample = v;
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() >= n) begin ok = 1; break; end
            step();
        end
        sample_valid = 0;
    endtask

    task automatic wait_cnt(input int target, output bit ok);
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            if ((m_clk % 256) == target) begin ok = 1; break; end
            step();
        end
    endtask

    task automatic wait_playing(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (PLAYING === 1'b1) begin ok = 1; break; end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1; cfg_en = 1; sample_valid = 1; cfg_div = 12'd255;
        step(); step();
        n_tests++; if (LEVEL !== 4'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", LEVEL); end
        n_tests++; if (PLAYING !== 1'b0) begin n_fail++; $display("FAIL reset_playing got %b want 0", PLAYING); end
        n_tests++; if (UNDERRUN !== 1'b0) begin n_fail++; $display("FAIL reset_underrun got %b want 0", UNDERRUN); end
        n_tests++; if (AUDIO_PWM !== 1'b0) begin n_fail++; $display("FAIL reset_pwm got %b want 0", AUDIO_PWM); end
        n_tests++; if (SAMPLE_READY !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", SAMPLE_READY); end
        n_tests++; if (fsm_state !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d want IDLE", fsm_state); end
        rst = 0; cfg_en = 0; sample_valid = 0;
        step();
    endtask

    task automatic test_prime_play();
        bit ok;
        int prev, pops, last;
        restart(255);
        ok = 0; sample_valid = 1;
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() >= 4) begin ok = 1; break; end
            sample = 8'($urandom);
            step();
        end
        sample_valid = 0;
        n_tests++; if (!ok || LEVEL !== 4'd4 || PLAYING !== 1'b0) begin n_fail++;
            $display("FAIL prime_level got level %0d playing %b want level 4 playing 0", LEVEL, PLAYING); end
        step();
        n_tests++; if (PLAYING !== 1'b1) begin n_fail++; $display("FAIL prime_play_rise got %b want 1", PLAYING); end
        prev = int'(LEVEL); pops = 0; last = 0;
        for (int c = 0; c < 1100; c++) begin
            step();
            if (int'(LEVEL) < prev) begin
                if (pops > 0) begin
                    n_tests++; if (c - last != 256) begin n_fail++;
                        $display("FAIL pop_spacing got %0d want 256", c - last); end
                end
                pops++; last = c;
            end
            prev = int'(LEVEL);
        end
        n_tests++; if (pops != 4) begin n_fail++; $display("FAIL pop_count got %0d want 4", pops); end
    endtask

    task automatic test_duty();
        logic [7:0] vals [3];
        bit ok;
        int high;
        vals[0] = 8'h00; vals[1] = 8'h7F; vals[2] = 8'h80;
        for (int k = 0; k < 3; k++) begin
            restart(63);
            sample = vals[k]; sample_valid = 1;
            wait_playing(ok);
            repeat (400) step();
            wait_cnt(1, ok);
            high = 0;
            for (int i = 0; i < 256; i++) begin
                high += int'(AUDIO_PWM);
                step();
            end
            n_tests++; if (!ok || high != (int'(vals[k]) + 128) % 256) begin n_fail++;
                $display("FAIL duty_%02h got %0d high want %0d", vals[k], high, (int'(vals[k]) + 128) % 256); end
        end
        sample_valid = 0;
    endtask

    task automatic test_underrun();
        bit ok;
        int high;
        restart(15);
        fill_to(4, 8'h7F, ok);
        underrun_clr = 1;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (UNDERRUN === 1'b1) begin ok = 1; break; end
            step();
        end
        n_tests++; if (!ok) begin n_fail++; $display("FAIL underrun_set got 0 want 1"); end
        n_tests++; if (fsm_state !== PRIME || PLAYING !== 1'b0) begin n_fail++;
            $display("FAIL underrun_state got %0d playing %b want PRIME playing 0", fsm_state, PLAYING); end
        step();
        n_tests++; if (UNDERRUN !== 1'b0) begin n_fail++; $display("FAIL underrun_clr got %b want 0", UNDERRUN); end
        underrun_clr = 0;
        wait_cnt(0, ok);
        step();
        high = 0;
        for (int i = 0; i < 256; i++) begin
            high += int'(AUDIO_PWM);
            step();
        end
        n_tests++; if (high != 128) begin n_fail++; $display("FAIL underrun_silence got %0d high want 128", high); end
    endtask

    task automatic test_full();
        bit ok;
        logic rdy7;
        restart(4095);
        rdy7 = 0; sample_valid = 1;
        for (int i = 0; i < 30 && LEVEL !== 4'd8; i++) begin
            if (LEVEL === 4'd7) rdy7 = SAMPLE_READY;
            sample = 8'($urandom);
            step();
        end
        n_tests++; if (LEVEL !== 4'd8 || SAMPLE_READY !== 1'b0 || rdy7 !== 1'b1) begin n_fail++;
            $display("FAIL full_ready got level %0d ready %b ready_at_7 %b want 8 0 1", LEVEL, SAMPLE_READY, rdy7); end
        step(); step();
        n_tests++; if (LEVEL !== 4'd8) begin n_fail++; $display("FAIL full_hold got %0d want 8", LEVEL); end
        restart(31);
        fill_to(5, 8'h11, ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (m_tick && m_state == PLAY) begin ok = 1; break; end
            step();
        end
        n_tests++; if (!ok || LEVEL !== 4'd5) begin n_fail++; $display("FAIL pushpop_pre got %0d want 5", LEVEL); end
        sample_valid = 1; sample = 8'h22;
        step();
        sample_valid = 0;
        n_tests++; if (LEVEL !== 4'd5) begin n_fail++; $display("FAIL pushpop_level got %0d want 5", LEVEL); end
    endtask

    task automatic test_disable();
        bit ok;
        restart(4095);
        fill_to(6, 8'h33, ok);
        n_tests++; if (!ok || LEVEL !== 4'd6 || PLAYING !== 1'b1) begin n_fail++;
            $display("FAIL disable_pre got level %0d playing %b want 6 1", LEVEL, PLAYING); end
        cfg_en = 0;
        step();
        n_tests++; if (fsm_state !== IDLE || LEVEL !== 4'd0 || SAMPLE_READY !== 1'b0 || PLAYING !== 1'b0) begin n_fail++;
            $display("FAIL disable got state %0d level %0d ready %b playing %b want IDLE 0 0 0", fsm_state, LEVEL, SAMPLE_READY, PLAYING); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        restart(63);
        sample = 8'h7F; sample_valid = 1;
        wait_playing(ok);
        repeat (400) step();
        wait_cnt(100, ok);
        n_tests++; if (!ok || AUDIO_PWM !== m_pwm || PLAYING !== 1'b1) begin n_fail++;
            $display("FAIL midrst_pre got pwm %b playing %b want %b 1", AUDIO_PWM, PLAYING, m_pwm); end
        rst = 1;
        step();
        n_tests++; if (AUDIO_PWM !== 1'b0 || LEVEL !== 4'd0 || PLAYING !== 1'b0 || UNDERRUN !== 1'b0 ||
                       SAMPLE_READY !== 1'b0 || fsm_state !== IDLE) begin n_fail++;
            $display("FAIL midrst got pwm %b level %0d playing %b underrun %b ready %b state %0d want all reset",
                     AUDIO_PWM, LEVEL, PLAYING, UNDERRUN, SAMPLE_READY, fsm_state); end
        rst = 0; cfg_en = 0; sample_valid = 0;
        step();
    endtask

    task automatic test_random();
        int rate;
        for (int seg = 0; seg < 6; seg++) begin
            restart($urandom_range(0, 24));
            rate = $urandom_range(20, 90);
            for (int c = 0; c < 500; c++) begin
                sample_valid = ($urandom_range(0, 99) < rate);
                sample       = 8'($urandom);
                underrun_clr = ($urandom_range(0, 15) == 0);
                rst          = ($urandom_range(0, 999) == 0);
                step();
                n_tests++;
                if (int'(LEVEL) != exp_q.size() || PLAYING !== (m_state == PLAY) || UNDERRUN !== m_under ||
                    AUDIO_PWM !== m_pwm || SAMPLE_READY !== (m_en_q && exp_q.size() < DEPTH) ||
                    fsm_state !== m_state) begin
                    n_fail++;
                    $display("FAIL random seg %0d cyc %0d got lvl %0d ply %b ur %b pwm %b rdy %b st %0d want %0d %b %b %b %b %0d",
                             seg, c, LEVEL, PLAYING, UNDERRUN, AUDIO_PWM, SAMPLE_READY, fsm_state,
                             exp_q.size(), m_state == PLAY, m_under, m_pwm, m_en_q && exp_q.size() < DEPTH, m_state);
                    rst = 0;
                    return;
                end
            end
            rst = 0;
        end
    endtask

    initial begin
        @(negedge CLK12);
        test_reset();
        test_prime_play();
        test_duty();
        test_underrun();
        test_full();
        test_disable();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
